// File: rtl/mips_fetch_pkg.sv
// Shared types and constants for the instruction-fetch sequencer.
// Holds the fetch FSM state encoding and the default fetch constants.
package mips_fetch_pkg;

  typedef enum logic [2:0] {
    ST_BOOT,
    ST_REQ,
    ST_HOLD,
    ST_LOAD,
    ST_HALT
  } fetch_state_e;

  localparam logic [31:0] DEF_PC_INC    = 32'd4;
  localparam logic [31:0] DEF_HALT_WORD = 32'h0000000C;
  localparam int          DEF_TIMEOUT   = 16;
  localparam logic [1:0]  WORD_ALIGN    = 2'b00;

endpackage

// File: rtl/fetch_timeout_counter.sv
// Counts consecutive un-served request cycles; expired flags the cycle whose
// miss would make the count reach TIMEOUT, so a ready in that cycle still wins.
module fetch_timeout_counter #(
  parameter int TIMEOUT = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);

  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (clear) begin
      count_d = '0;
    end else if (enable) begin
      count_d = count_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign expired = enable && (count_q == CNT_W'(TIMEOUT - 1));

endmodule

// File: rtl/fetch_sequencer.sv
// Multi-cycle fetch sequencer: fetches the word at pc, holds it for execute,
// then steers the PC register via target/pc_load; halts on syscall or fault.
module fetch_sequencer
  import mips_fetch_pkg::*;
#(
  parameter logic [31:0] PC_INC    = DEF_PC_INC,
  parameter int          TIMEOUT   = DEF_TIMEOUT,
  parameter logic [31:0] HALT_WORD = DEF_HALT_WORD
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] pc,
  output logic        pc_load,
  output logic [31:0] target,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic [31:0] imem_rdata,
  output logic [31:0] instr,
  output logic        instr_valid,
  input  logic        instr_accept,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_target,
  output logic        halt,
  output logic        fault
);

  fetch_state_e state_q, state_d;
  logic [31:0]  target_q, target_d;
  logic [31:0]  instr_q, instr_d;
  logic         pc_load_q, pc_load_d;
  logic         imem_req_q, imem_req_d;
  logic         instr_valid_q, instr_valid_d;
  logic         halt_q, halt_d;
  logic         fault_q, fault_d;
  logic         tmo_clear;
  logic         tmo_enable;
  logic         tmo_expired;

  fetch_timeout_counter #(
    .TIMEOUT (TIMEOUT)
  ) u_timeout (
    .clk     (clk),
    .reset   (reset),
    .clear   (tmo_clear),
    .enable  (tmo_enable),
    .expired (tmo_expired)
  );

  always_comb begin
    state_d    = state_q;
    target_d   = target_q;
    instr_d    = instr_q;
    halt_d     = halt_q;
    fault_d    = fault_q;
    tmo_clear  = 1'b1;
    tmo_enable = 1'b0;

    case (state_q)
      ST_BOOT: state_d = ST_REQ;

      ST_REQ: begin
        tmo_clear  = imem_ready;
        tmo_enable = !imem_ready;
        if (imem_ready) begin
          instr_d = imem_rdata;
          state_d = ST_HOLD;
        end else if (tmo_expired) begin
          fault_d = 1'b1;
          halt_d  = 1'b1;
          state_d = ST_HALT;
        end
      end

      // Priority: syscall, then misaligned redirect, then taken redirect, then sequential.
      ST_HOLD: begin
        if (instr_accept) begin
          if (instr_q == HALT_WORD) begin
            halt_d  = 1'b1;
            state_d = ST_HALT;
          end else if (redirect_valid && (redirect_target[1:0] != WORD_ALIGN)) begin
            fault_d = 1'b1;
            halt_d  = 1'b1;
            state_d = ST_HALT;
          end else if (redirect_valid) begin
            target_d = redirect_target;
            state_d  = ST_LOAD;
          end else begin
            target_d = pc + PC_INC;
            state_d  = ST_LOAD;
          end
        end
      end

      ST_LOAD: state_d = ST_REQ;

      ST_HALT: state_d = ST_HALT;

      default: state_d = ST_HALT;
    endcase

    // Handshake outputs are pure functions of the state being entered.
    imem_req_d    = (state_d == ST_REQ);
    pc_load_d     = (state_d == ST_LOAD);
    instr_valid_d = (state_d == ST_HOLD);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= ST_BOOT;
      target_q      <= '0;
      instr_q       <= '0;
      pc_load_q     <= 1'b0;
      imem_req_q    <= 1'b0;
      instr_valid_q <= 1'b0;
      halt_q        <= 1'b0;
      fault_q       <= 1'b0;
    end else begin
      state_q       <= state_d;
      target_q      <= target_d;
      instr_q       <= instr_d;
      pc_load_q     <= pc_load_d;
      imem_req_q    <= imem_req_d;
      instr_valid_q <= instr_valid_d;
      halt_q        <= halt_d;
      fault_q       <= fault_d;
    end
  end

  assign imem_addr   = pc;
  assign pc_load     = pc_load_q;
  assign target      = target_q;
  assign imem_req    = imem_req_q;
  assign instr       = instr_q;
  assign instr_valid = instr_valid_q;
  assign halt        = halt_q;
  assign fault       = fault_q;

endmodule
